// File: rtl/cdb_broadcaster_if.sv
// Source-side completion handshake plus CDB broadcast / RS release outputs.
// The DUT connects through the slave modport; producers and observers use master.
interface cdb_broadcaster_if #(
    parameter int NUM_SRC  = 4,
    parameter int PREG_W   = 6,
    parameter int RS_IDX_W = 3
);
    // Handshake: a transfer on source i happens at a rising clock edge where
    // src_valid[i] && src_ready[i]. src_ready[i] depends only on FIFO i's
    // occupancy, never on src_valid. A source holds src_valid, src_tag and
    // src_rs_idx stable until the transfer occurs. cdb_en / remove_en are
    // single-cycle pulses with no backpressure.
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC*PREG_W-1:0]   src_tag;
    logic [NUM_SRC*RS_IDX_W-1:0] src_rs_idx;
    logic [NUM_SRC-1:0]          src_ready;

    logic                        cdb_en;
    logic [PREG_W-1:0]           cdb_tag;
    logic                        remove_en;
    logic [RS_IDX_W-1:0]         remove_idx;

    modport master (
        output src_valid, src_tag, src_rs_idx,
        input  src_ready, cdb_en, cdb_tag, remove_en, remove_idx
    );

    modport slave (
        input  src_valid, src_tag, src_rs_idx,
        output src_ready, cdb_en, cdb_tag, remove_en, remove_idx
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Per-source completion FIFOs feeding a round-robin arbiter that drives one CDB
// broadcast and one RS-entry release per cycle. Optional macro: CDB_BYPASS_EN.
module cdb_broadcaster #(
    parameter int NUM_SRC  = 4,
    parameter int DEPTH    = 2,
    parameter int PREG_W   = 6,
    parameter int RS_IDX_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                interrupt,
    cdb_broadcaster_if.slave    bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // FIFO storage and bookkeeping
    logic [PREG_W-1:0]   tag_mem [NUM_SRC][DEPTH];
    logic [RS_IDX_W-1:0] idx_mem [NUM_SRC][DEPTH];
    logic [PTR_W-1:0]    rd_ptr  [NUM_SRC];
    logic [PTR_W-1:0]    wr_ptr  [NUM_SRC];
    logic [CNT_W-1:0]    count   [NUM_SRC];
    logic [RR_W-1:0]     rr_ptr;

    // Unpacked request fields
    logic [PREG_W-1:0]   in_tag  [NUM_SRC];
    logic [RS_IDX_W-1:0] in_idx  [NUM_SRC];

    logic [NUM_SRC-1:0]  ready;
    logic [NUM_SRC-1:0]  non_empty;
    logic [NUM_SRC-1:0]  accept;
    logic [NUM_SRC-1:0]  req;
    logic [NUM_SRC-1:0]  push;
    logic [NUM_SRC-1:0]  pop;

    logic                grant_any;
    logic                grant_fire;
    logic [NUM_SRC-1:0]  grant_oh;
    logic [RR_W-1:0]     grant_src;
    logic [RR_W-1:0]     next_rr;
    logic                grant_bypass;
    logic [PREG_W-1:0]   grant_tag;
    logic [RS_IDX_W-1:0] grant_idx;

    // Output register
    logic                cdb_en_q;
    logic [PREG_W-1:0]   cdb_tag_q;
    logic                remove_en_q;
    logic [RS_IDX_W-1:0] remove_idx_q;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_tag[i] = bus.src_tag[i*PREG_W +: PREG_W];
            in_idx[i] = bus.src_rs_idx[i*RS_IDX_W +: RS_IDX_W];
        end
    end

    // Ready comes from occupancy alone; a same-cycle pop never opens a full FIFO.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            ready[i]     = (count[i] != CNT_W'(DEPTH));
            non_empty[i] = (count[i] != '0);
            accept[i]    = bus.src_valid[i] & ready[i] & ~interrupt;
`ifdef CDB_BYPASS_EN
            req[i]       = non_empty[i] | accept[i];
`else
            req[i]       = non_empty[i];
`endif
        end
    end

    assign bus.src_ready = ready;

    // Round-robin search starting at rr_ptr
    always_comb begin
        int s;
        s         = 0;
        grant_any = 1'b0;
        grant_oh  = '0;
        grant_src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= NUM_SRC) begin
                s = s - NUM_SRC;
            end
            if (!grant_any && req[s]) begin
                grant_any   = 1'b1;
                grant_oh[s] = 1'b1;
                grant_src   = RR_W'(s);
            end
        end
    end

    assign grant_fire = grant_any & ~interrupt;
    assign next_rr    = (grant_src == RR_W'(NUM_SRC - 1)) ? '0 : grant_src + 1'b1;

    // Granted payload: FIFO head, or the live request when bypassing an empty FIFO
    always_comb begin
        grant_bypass = 1'b0;
        grant_tag    = tag_mem[grant_src][rd_ptr[grant_src]];
        grant_idx    = idx_mem[grant_src][rd_ptr[grant_src]];
`ifdef CDB_BYPASS_EN
        if (!non_empty[grant_src]) begin
            grant_bypass = 1'b1;
            grant_tag    = in_tag[grant_src];
            grant_idx    = in_idx[grant_src];
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]  = grant_fire & grant_oh[i] & non_empty[i];
            push[i] = accept[i] & ~(grant_fire & grant_oh[i] & grant_bypass);
        end
    end

    // FIFO pointers, counts and arbiter pointer; interrupt flushes like reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= '0;
        end else if (interrupt) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
            if (grant_fire) begin
                rr_ptr <= next_rr;
            end
        end
    end

    // Payload storage carries no reset; only count decides what is valid
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]] <= in_tag[i];
                idx_mem[i][wr_ptr[i]] <= in_idx[i];
            end
        end
    end

    // Tag 0 is an x0 destination: release the RS slot but never wake comparators
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_en_q     <= 1'b0;
            cdb_tag_q    <= '0;
            remove_en_q  <= 1'b0;
            remove_idx_q <= '0;
        end else if (grant_fire) begin
            remove_en_q  <= 1'b1;
            remove_idx_q <= grant_idx;
            cdb_en_q     <= (grant_tag != '0);
            if (grant_tag != '0) begin
                cdb_tag_q <= grant_tag;
            end
        end else begin
            cdb_en_q    <= 1'b0;
            remove_en_q <= 1'b0;
        end
    end

    assign bus.cdb_en     = cdb_en_q;
    assign bus.cdb_tag    = cdb_tag_q;
    assign bus.remove_en  = remove_en_q;
    assign bus.remove_idx = remove_idx_q;

endmodule
